hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage core (IF/ID/EX/MEM/WB) inside main.
- Keeps a scoreboard of destination registers in EX/MEM/WB and detects RAW hazards against the instruction in ID.
- Drives the stall/bubble request and operand-forward selects, and sequences halt drain.
- Provides the stall counters that main exports as stall_w_forewarding and stall_wo_forewarding.

Parameters:
- REG_AW, 5, register-index width (32 architectural registers; index 0 never creates a hazard).
- CNT_W, 32, width of the stall counters.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- fwd_en  in  1  1 = forwarding mode, 0 = no-forwarding mode; sampled every cycle.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  REG_AW  source register indices.
- id_use_rs, id_use_rt  in  1  source is actually read.
- id_dst  in  REG_AW  destination register index.
- id_wr  in  1  instruction writes id_dst.
- id_load  in  1  instruction is a load.
- id_halt  in  1  HALT opcode (6'b010001) decoded in ID.
- flush  in  1  taken branch/jump; kill the ID instruction.
- stall  out  1  combinational; hold PC and IF/ID, insert a bubble into EX.
- fwd_a, fwd_b  out  2  registered; operand select for the instruction now in EX. 00 = regfile, 01 = EX/MEM result, 10 = MEM/WB result.
- halted  out  1  pipeline drained after HALT.
- stall_cnt  out  CNT_W  stall cycles in the active mode.
- stall_wo_cnt  out  CNT_W  shadow no-forwarding stall count (optional feature).

Behaviour:
- Reset: all outputs 0; scoreboard entries invalid; state RUN.
- Scoreboard: three entries EX/MEM/WB, each holding {v, dst, load}.
  - Every cycle MEM->WB and EX->MEM shift.
  - EX loads the ID instruction if it is accepted; otherwise EX loads a bubble (v=0).
  - An entry matches a source when v && wr && dst!=0 && dst==src && use_src.
- Hazard with fwd_en=1:
  - stall=1 iff the EX entry is a load and matches rs or rt (load-use, exactly 1 cycle).
  - Forward selects are computed at ID accept and registered. EX-entry match -> 01; else MEM-entry match -> 10; else 00. rs and rt are resolved independently.
- Hazard with fwd_en=0:
  - stall=1 while the EX or MEM entry matches. An EX match gives 2 stall cycles; a MEM match gives 1.
  - A WB match never stalls (regfile writes in the first half-cycle).
  - fwd_a = fwd_b = 00.
- Accept condition: id_valid && !stall && !flush && state==RUN.
- flush has priority over stall: stall is forced 0, EX gets a bubble, and no count increments.
- States:
  - RUN: on an accepted id_halt, the HALT enters EX as a bubble and the state goes to DRAIN.
  - DRAIN: stall=1 every cycle (PC frozen); no counting. When EX, MEM and WB are all invalid, go to HALTED.
  - HALTED: halted=1 and stall=1; terminal until reset.
  - Reset asserted in any state returns to RUN with an empty scoreboard.
- stall_cnt increments by 1 in each RUN-state cycle with stall=1. It saturates at all-ones.

Optional Feature:
- Macro: HAZARD_SHADOW_CNT_EN.
- Defined: stall_wo_cnt accumulates the stalls the no-forwarding policy would incur, independent of fwd_en.
  - On each accepted instruction, add the producer distance: 2 if a valid producer was in EX when the consumer first reached ID, 1 if it was in MEM, else 0. Take the maximum over rs/rt.
  - The adder saturates at all-ones.
  - This lets one run report both totals.
- Undefined: stall_wo_cnt is tied to 0 and the shadow logic is absent.

Decomposition:
- Shared package (struct.sv): sb_entry_t {v, dst, load, wr}, fwd_sel_e {FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10}, hz_state_e {RUN, DRAIN, HALTED}, and OPC_HALT=6'b010001.
- One sub-module, hazard_match: combinational comparison of one source against one sb_entry_t, instantiated per source per stage.

Test Plan:
- fwd_en=1, "lw r2,0(r1); add r3,r2,r4" -> stall high 1 cycle; add reaches EX with fwd_a=10; stall_cnt=1.
- fwd_en=1, "add r3,r1,r2; sub r5,r3,r3" -> no stall; fwd_a=fwd_b=01; stall_cnt=0.
- fwd_en=0, same add/sub pair -> 2 stall cycles, fwd 00, stall_cnt=2; with the next instruction reading r3 at distance 2 -> 1 stall.
- Dependency on r0 ("add r0,..; add r4,r0,r0") in both modes -> no stall, fwd 00.
- flush asserted in the same cycle as a load-use hazard -> stall=0, EX bubble, stall_cnt unchanged.
- HALT issued behind 3 in-flight instructions -> DRAIN for 3 cycles, then halted=1; reset pulse mid-DRAIN -> RUN, all counters 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard controller: scoreboard entry, forward selects,
// FSM states, debug view and the forward-select priority helper.
package hazard_ctrl_pkg;

    localparam int SB_AW = 5;
    localparam logic [5:0] OPC_HALT = 6'b010001;

    typedef struct packed {
        logic             v;
        logic [SB_AW-1:0] dst;
        logic             load;
        logic             wr;
    } sb_entry_t;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } hz_state_e;

    typedef struct packed {
        hz_state_e state;
        sb_entry_t ex;
        sb_entry_t mem;
        sb_entry_t wb;
    } hz_dbg_t;

    // The youngest producer wins, so an EX hit takes priority over a MEM hit.
    function automatic fwd_sel_e fwd_pick(input logic hit_ex, input logic hit_mem);
        if (hit_ex) return FWD_EXMEM;
        if (hit_mem) return FWD_MEMWB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_match.sv
// Compares one ID source register against one scoreboard entry.
module hazard_match
    import hazard_ctrl_pkg::*;
(
    input  sb_entry_t        entry,
    input  logic [SB_AW-1:0] src,
    input  logic             use_src,
    output logic             hit
);

    assign hit = entry.v && entry.wr && (entry.dst != '0) && (entry.dst == src) && use_src;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX/MEM/WB scoreboard, stall/forward generation,
// HALT drain FSM and stall counters. Define HAZARD_SHADOW_CNT_EN for the shadow count.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = SB_AW,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fwd_en,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_wr,
    input  logic              id_load,
    input  logic              id_halt,
    input  logic              flush,
    output logic              stall,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  stall_wo_cnt,
    output hz_dbg_t           dbg
);

    sb_entry_t        ex_q, ex_d, mem_q, wb_q;
    hz_state_e        state_q, state_d;
    fwd_sel_e         fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic hit_ex_rs, hit_ex_rt, hit_mem_rs, hit_mem_rt;
    logic hazard, stall_c, accept;

    hazard_match u_ex_rs  (.entry(ex_q),  .src(id_rs), .use_src(id_use_rs), .hit(hit_ex_rs));
    hazard_match u_ex_rt  (.entry(ex_q),  .src(id_rt), .use_src(id_use_rt), .hit(hit_ex_rt));
    hazard_match u_mem_rs (.entry(mem_q), .src(id_rs), .use_src(id_use_rs), .hit(hit_mem_rs));
    hazard_match u_mem_rt (.entry(mem_q), .src(id_rt), .use_src(id_use_rt), .hit(hit_mem_rt));

    // A WB producer writes the regfile in the first half-cycle, so it never stalls.
    always_comb begin
        hazard = 1'b0;
        if (fwd_en) begin
            hazard = ex_q.load && (hit_ex_rs || hit_ex_rt);
        end else begin
            hazard = hit_ex_rs || hit_ex_rt || hit_mem_rs || hit_mem_rt;
        end
    end

    always_comb begin
        stall_c = 1'b0;
        if (flush) begin
            stall_c = 1'b0;
        end else if (state_q != RUN) begin
            stall_c = 1'b1;
        end else begin
            stall_c = id_valid && hazard;
        end
    end

    assign accept = id_valid && !stall_c && !flush && (state_q == RUN);

    always_comb begin
        ex_d    = '0;
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        state_d = state_q;
        cnt_d   = cnt_q;

        // HALT itself enters EX as a bubble.
        if (accept && !id_halt) begin
            ex_d.v    = 1'b1;
            ex_d.dst  = id_dst;
            ex_d.load = id_load;
            ex_d.wr   = id_wr;
            if (fwd_en) begin
                fwd_a_d = fwd_pick(hit_ex_rs, hit_mem_rs);
                fwd_b_d = fwd_pick(hit_ex_rt, hit_mem_rt);
            end
        end

        if ((state_q == RUN) && stall_c && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            RUN: begin
                if (accept && id_halt) state_d = DRAIN;
            end
            DRAIN: begin
                if (!ex_q.v && !mem_q.v && !wb_q.v) state_d = HALTED;
            end
            HALTED: state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            state_q <= RUN;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            wb_q    <= mem_q;
            state_q <= state_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_SHADOW_CNT_EN
    logic             held_q, held_d;
    logic [1:0]       dist_q, dist_d, dist_now;
    logic [CNT_W-1:0] wo_q, wo_d;
    logic [CNT_W:0]   wo_sum;

    // The producer distance is frozen on the first ID cycle of an instruction;
    // later stall cycles would otherwise see the producer move further away.
    always_comb begin
        dist_now = 2'd0;
        if (hit_ex_rs || hit_ex_rt) begin
            dist_now = 2'd2;
        end else if (hit_mem_rs || hit_mem_rt) begin
            dist_now = 2'd1;
        end
        dist_d = held_q ? dist_q : dist_now;
        held_d = id_valid && stall_c;
        wo_sum = {1'b0, wo_q} + (CNT_W + 1)'(dist_d);
        wo_d   = wo_q;
        if (accept) begin
            wo_d = wo_sum[CNT_W] ? '1 : wo_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            held_q <= 1'b0;
            dist_q <= 2'd0;
            wo_q   <= '0;
        end else begin
            held_q <= held_d;
            dist_q <= dist_d;
            wo_q   <= wo_d;
        end
    end

    assign stall_wo_cnt = wo_q;
`else
    assign stall_wo_cnt = '0;
`endif

    assign stall     = stall_c;
    assign fwd_a     = fwd_a_q;
    assign fwd_b     = fwd_b_q;
    assign halted    = (state_q == HALTED);
    assign stall_cnt = cnt_q;

    always_comb begin
        dbg       = '0;
        dbg.state = state_q;
        dbg.ex    = ex_q;
        dbg.mem   = mem_q;
        dbg.wb    = wb_q;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic checked
// against a register-age reference model.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int CW     = 6;
  localparam int CMAX_I = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          fwd_en = 1'b1;
  logic          id_valid = 1'b0;
  logic [4:0]    id_rs = '0, id_rt = '0, id_dst = '0;
  logic          id_use_rs = 1'b0, id_use_rt = 1'b0;
  logic          id_wr = 1'b0, id_load = 1'b0, id_halt = 1'b0, flush = 1'b0;
  logic          stall, halted;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, stall_wo_cnt;
  hz_dbg_t       dbg;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .fwd_en(fwd_en), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_dst(id_dst), .id_wr(id_wr), .id_load(id_load), .id_halt(id_halt),
    .flush(flush), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted),
    .stall_cnt(stall_cnt), .stall_wo_cnt(stall_wo_cnt), .dbg(dbg)
  );

  // Reference model: per-register issue time of the youngest writer, so a
  // producer's pipeline position is just its age in cycles (1=EX, 2=MEM, 3=WB).
  longint    now;
  longint    wr_time[32];
  bit        wr_load[32];
  bit [2:0]  hist;
  int        mode;
  logic [1:0] m_fwd_a, m_fwd_b;
  int        m_cnt, m_wo, cur_dist;
  bit        m_held;
  logic      obs_stall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int age(input logic [4:0] r, input logic use_r);
    longint a;
    if (!use_r || r == 5'd0) return 0;
    a = now - wr_time[r];
    if (a > 3) return 0;
    return int'(a);
  endfunction

  function automatic int dist_of(input int a);
    if (a == 1) return 2;
    if (a == 2) return 1;
    return 0;
  endfunction

  function automatic logic [1:0] sel_of(input int a);
    if (a == 1) return 2'b01;
    if (a == 2) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      wr_time[i] = -100;
      wr_load[i] = 1'b0;
    end
    hist = '0; mode = 0; m_fwd_a = '0; m_fwd_b = '0;
    m_cnt = 0; m_wo = 0; cur_dist = 0; m_held = 1'b0;
  endtask

  task automatic set_ins(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                         input bit urs, input bit urt, input logic [4:0] dst,
                         input bit wr, input bit ld, input bit hlt);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_dst = dst; id_wr = wr; id_load = ld; id_halt = hlt;
  endtask

  task automatic check_outputs(input bit e_stall);
    hz_state_e exp_state;
    int exp_wo;
    exp_state = (mode == 0) ? RUN : (mode == 1) ? DRAIN : HALTED;
`ifdef HAZARD_SHADOW_CNT_EN
    exp_wo = m_wo;
`else
    exp_wo = 0;
`endif
    chk("stall", stall, e_stall);
    chk("fwd_a", fwd_a, m_fwd_a);
    chk("fwd_b", fwd_b, m_fwd_b);
    chk("halted", halted, mode == 2);
    chk("stall_cnt", stall_cnt, m_cnt);
    chk("stall_wo_cnt", stall_wo_cnt, exp_wo);
    chk("state", dbg.state, exp_state);
    chk("sb_valid", {dbg.ex.v, dbg.mem.v, dbg.wb.v}, hist);
  endtask

  // One clock: inputs already driven; check, advance the model, cross the edge.
  task automatic cyc();
    int a_rs, a_rt, next_mode;
    bit haz, e_stall, acc;
    #1;
    a_rs = age(id_rs, id_use_rs);
    a_rt = age(id_rt, id_use_rt);
    if (fwd_en) haz = (a_rs == 1 && wr_load[id_rs]) || (a_rt == 1 && wr_load[id_rt]);
    else        haz = (a_rs == 1 || a_rs == 2 || a_rt == 1 || a_rt == 2);
    e_stall = flush ? 1'b0 : (mode != 0) ? 1'b1 : (id_valid && haz);
    acc = id_valid && !e_stall && !flush && (mode == 0);
    if (!m_held) cur_dist = (dist_of(a_rs) > dist_of(a_rt)) ? dist_of(a_rs) : dist_of(a_rt);

    check_outputs(e_stall);
    obs_stall = stall;

    next_mode = mode;
    if (mode == 1 && hist == 3'b000) next_mode = 2;
    if (mode == 0 && e_stall && m_cnt < CMAX_I) m_cnt++;
    m_fwd_a = 2'b00;
    m_fwd_b = 2'b00;
    if (acc && !id_halt) begin
      if (fwd_en) begin
        m_fwd_a = sel_of(a_rs);
        m_fwd_b = sel_of(a_rt);
      end
      if (id_wr && id_dst != 5'd0) begin
        wr_time[id_dst] = now;
        wr_load[id_dst] = id_load;
      end
    end
    if (acc && id_halt) next_mode = 1;
    if (acc) m_wo = (m_wo + cur_dist > CMAX_I) ? CMAX_I : m_wo + cur_dist;
    hist = {acc && !id_halt, hist[2:1]};
    m_held = id_valid && e_stall;
    mode = next_mode;
    now++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0);
    flush = 1'b0;
    cyc();
  endtask

  // Present one instruction and hold it until the DUT accepts it (bounded).
  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input bit urs,
                       input bit urt, input logic [4:0] dst, input bit wr,
                       input bit ld, input bit hlt);
    int n;
    n = 0;
    flush = 1'b0;
    set_ins(1, rs, rt, urs, urt, dst, wr, ld, hlt);
    cyc();
    while (obs_stall && n < 8) begin
      cyc();
      n++;
    end
    if (n == 8) chk("issue_timeout", obs_stall, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    flush = 1'b0;
    set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    chk("rst_stall", stall, 1'b0);
    chk("rst_fwd", {fwd_a, fwd_b}, 4'b0000);
    chk("rst_halted", halted, 1'b0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_wo_cnt", stall_wo_cnt, 0);
    chk("rst_state", dbg.state, RUN);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    now = 0;
    model_reset();

    // lw r2,0(r1); add r3,r2,r4 with forwarding
    fwd_en = 1'b1;
    do_reset();
    issue(1, 0, 1, 0, 2, 1, 1, 0);
    issue(2, 4, 1, 1, 3, 1, 0, 0);
    chk("t1_fwd_a", fwd_a, 2'b10);
    chk("t1_cnt", stall_cnt, 1);
    idle();

    // add r3,r1,r2; sub r5,r3,r3 with forwarding
    do_reset();
    issue(1, 2, 1, 1, 3, 1, 0, 0);
    issue(3, 3, 1, 1, 5, 1, 0, 0);
    chk("t2_fwd", {fwd_a, fwd_b}, 4'b0101);
    chk("t2_cnt", stall_cnt, 0);
    idle();

    // same pair without forwarding, then a distance-2 consumer
    fwd_en = 1'b0;
    do_reset();
    issue(1, 2, 1, 1, 3, 1, 0, 0);
    issue(3, 3, 1, 1, 5, 1, 0, 0);
    chk("t3_fwd", {fwd_a, fwd_b}, 4'b0000);
    chk("t3_cnt", stall_cnt, 2);
    do_reset();
    issue(1, 2, 1, 1, 3, 1, 0, 0);
    issue(1, 1, 1, 1, 7, 1, 0, 0);
    issue(3, 3, 1, 1, 6, 1, 0, 0);
    chk("t3b_cnt", stall_cnt, 1);
    idle();

    // r0 dependency in both modes
    for (int m = 0; m < 2; m++) begin
      fwd_en = m[0];
      do_reset();
      issue(1, 2, 1, 1, 0, 1, 1, 0);
      issue(0, 0, 1, 1, 4, 1, 0, 0);
      chk("t4_fwd", {fwd_a, fwd_b}, 4'b0000);
      chk("t4_cnt", stall_cnt, 0);
    end

    // flush on top of a load-use hazard
    fwd_en = 1'b1;
    do_reset();
    issue(1, 0, 1, 0, 2, 1, 1, 0);
    set_ins(1, 2, 4, 1, 1, 3, 1, 0, 0);
    flush = 1'b1;
    cyc();
    chk("t5_flush_stall", obs_stall, 1'b0);
    chk("t5_ex_bubble", dbg.ex.v, 1'b0);
    chk("t5_cnt", stall_cnt, 0);
    idle();

    // HALT behind three in-flight instructions
    do_reset();
    issue(1, 2, 1, 1, 3, 1, 0, 0);
    issue(1, 2, 1, 1, 4, 1, 0, 0);
    issue(1, 2, 1, 1, 5, 1, 0, 0);
    issue(0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      chk("t6_drain_state", dbg.state, DRAIN);
      chk("t6_not_halted", halted, 1'b0);
      idle();
    end
    chk("t6_halted", halted, 1'b1);
    chk("t6_halt_stall", obs_stall, 1'b1);
    idle();
    chk("t6_halted_stays", halted, 1'b1);

    // reset pulse in the middle of DRAIN
    fwd_en = 1'b0;
    do_reset();
    issue(1, 2, 1, 1, 3, 1, 0, 0);
    issue(3, 3, 1, 1, 5, 1, 0, 0);
    issue(1, 2, 1, 1, 6, 1, 0, 0);
    issue(0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    chk("t6b_drain", dbg.state, DRAIN);
    chk("t6b_cnt", stall_cnt, 2);
    do_reset();
    issue(1, 2, 1, 1, 3, 1, 0, 0);
    issue(3, 1, 1, 1, 5, 1, 0, 0);
    chk("t6b_after_cnt", stall_cnt, 2);

    // saturation: chained r1 dependencies without forwarding, two stalls each
    do_reset();
    for (int k = 0; k < 40; k++) issue(1, 1, 1, 1, 1, 1, 0, 0);
    chk("sat_cnt", stall_cnt, CMAX_I);

    // randomized traffic
    for (int seg = 0; seg < 6; seg++) begin
      bit need_new;
      fwd_en = $urandom_range(0, 1);
      do_reset();
      need_new = 1'b1;
      for (int c = 0; c < 120; c++) begin
        if ($urandom_range(0, 15) == 0) fwd_en = ~fwd_en;
        if (need_new) begin
          if ($urandom_range(0, 99) == 0) begin
            set_ins(1, 0, 0, 0, 0, 0, 0, 0, 1);
          end else begin
            set_ins($urandom_range(0, 5) != 0,
                    5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 1),
                    5'($urandom_range(0, 4)), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 2) == 0, 1'b0);
          end
        end
        flush = ($urandom_range(0, 9) == 0);
        cyc();
        need_new = !(id_valid && obs_stall);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
